// File: rtl/mac_job_sched.sv
// Round-robin arbiter that lends one MAC_v4 datapath to two operand requesters,
// streaming one burst at a time and returning the tagged MAC result.
//
// state  | meaning
// IDLE   | no job; pick a requester (priority breaks ties)
// STREAM | granted requester's beats forwarded to the MAC, 1-cycle latency
// WAIT   | burst done; waiting for mac_out_valid or the timeout
// RESP   | result held on res_* until res_ready
module mac_job_sched #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_last,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_last,
  output logic       mac_in_valid,
  output logic [3:0] mac_in1,
  output logic [3:0] mac_in2,
  input  logic       mac_out_valid,
  input  logic [9:0] mac_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic [9:0] res_data,
  output logic [1:0] res_status
);

  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, RESP} state_t;

  state_t        state;
  logic          grant_id;
  logic          prio;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    status;

  logic          grant_nxt;
  logic          sel_valid;
  logic          sel_ready;
  logic          sel_last;
  logic [3:0]    sel_a;
  logic [3:0]    sel_b;
  logic          accept;
  logic          hit_max;

  always_comb begin
    grant_nxt = (req0_valid && req1_valid) ? prio : req1_valid;
    sel_valid = grant_id ? req1_valid : req0_valid;
    sel_ready = grant_id ? req1_ready : req0_ready;
    sel_last  = grant_id ? req1_last  : req0_last;
    sel_a     = grant_id ? req1_a     : req0_a;
    sel_b     = grant_id ? req1_b     : req0_b;
    accept    = (state == STREAM) && sel_valid && sel_ready;
    hit_max   = (beat_cnt == BW'(MAX_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_id     <= 1'b0;
      prio         <= 1'b0;
      beat_cnt     <= '0;
      to_cnt       <= '0;
      status       <= 2'b00;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      mac_in_valid <= 1'b0;
      mac_in1      <= 4'd0;
      mac_in2      <= 4'd0;
      res_valid    <= 1'b0;
      res_id       <= 1'b0;
      res_data     <= 10'd0;
      res_status   <= 2'b00;
    end else begin
      mac_in_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_id   <= grant_nxt;
            req0_ready <= ~grant_nxt;
            req1_ready <= grant_nxt;
            beat_cnt   <= '0;
            status     <= 2'b00;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            mac_in_valid <= 1'b1;
            mac_in1      <= sel_a;
            mac_in2      <= sel_b;
            beat_cnt     <= beat_cnt + 1'b1;
            if (sel_last || hit_max) begin
              req0_ready <= 1'b0;
              req1_ready <= 1'b0;
              to_cnt     <= '0;
              state      <= WAIT;
              if (!sel_last) status <= 2'b10;
            end
          end else if (beat_cnt != '0) begin
            // bubble after the first beat truncates the burst
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            to_cnt     <= '0;
            status     <= 2'b10;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (mac_out_valid) begin
            res_data   <= mac_out;
            res_status <= status;
            res_id     <= grant_id;
            res_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TW'(TIMEOUT - 1)) begin
              res_data   <= 10'd0;
              res_status <= 2'b01;
              res_id     <= grant_id;
              res_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            prio      <= ~grant_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
